// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_ctrl.
// The datapath side drives hazard sources; the controller drives segment hold/clear controls.
interface pipe_ctrl_if;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic        rs1_useD;
    logic        rs2_useD;
    logic [4:0]  rdE;
    logic        mem_readE;
    logic        br_takenE;
    logic        jalrE;
    logic        jalD;
    logic        csrD;
    logic        missM;
    logic        mem_ack;
    logic        bubbleF;
    logic        bubbleD;
    logic        bubbleE;
    logic        bubbleM;
    logic        bubbleW;
    logic        flushF;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic        flushW;
    logic [15:0] miss_cycles;

    modport master (
        output rs1D, rs2D, rs1_useD, rs2_useD, rdE, mem_readE,
               br_takenE, jalrE, jalD, csrD, missM, mem_ack,
        input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW, miss_cycles
    );

    modport slave (
        input  rs1D, rs2D, rs1_useD, rs2_useD, rdE, mem_readE,
               br_takenE, jalrE, jalD, csrD, missM, mem_ack,
        output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW, miss_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: D-cache miss freeze, load-use stall, EX/JAL redirects.
// Optional CSR serialization (3-cycle drain before a CSR issues) is enabled by macro CSR_SERIALIZE_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] miss_cycles_r;
    logic        miss_inc_s;
    logic        load_use_s;
    logic        redirect_s;
    logic [4:0]  bub_s;
    logic [4:0]  fl_s;
`ifdef CSR_SERIALIZE_EN
    logic [1:0]  drain_cnt_r;
    logic [1:0]  drain_cnt_nxt_s;
`else
    logic        unused_csr_s;
    assign unused_csr_s = bus.csrD;
`endif

    localparam logic [4:0] ALL_5  = 5'b11111;
    localparam logic [4:0] NONE_5 = 5'b00000;
    // F and D hold, E receives a bubble: the ID instruction waits one cycle
    localparam logic [4:0] STALL_BUB = 5'b11000;
    localparam logic [4:0] STALL_FL  = 5'b00100;
    localparam logic [4:0] REDIR_FL  = 5'b01100;
    localparam logic [4:0] JAL_FL    = 5'b01000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Hazard detection from ID/EX operands
    always_comb begin
        redirect_s = bus.br_takenE | bus.jalrE;
        load_use_s = bus.mem_readE && (bus.rdE != 5'd0) &&
                     (((bus.rdE == bus.rs1D) && bus.rs1_useD) ||
                      ((bus.rdE == bus.rs2D) && bus.rs2_useD));
    end

    // Next-state and segment control decode, priority: reset, miss, redirect, drain/load-use, jal
    always_comb begin
        state_nxt_s = state_r;
        miss_inc_s  = 1'b0;
        bub_s       = NONE_5;
        fl_s        = NONE_5;
`ifdef CSR_SERIALIZE_EN
        drain_cnt_nxt_s = drain_cnt_r;
`endif
        if (!rst_n) begin
            fl_s = ALL_5;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.missM) begin
                        bub_s       = ALL_5;
                        state_nxt_s = MISS_WAIT;
                    end else if (redirect_s) begin
                        fl_s = REDIR_FL;
`ifdef CSR_SERIALIZE_EN
                        drain_cnt_nxt_s = 2'd0;
`endif
                    end else if (load_use_s) begin
                        bub_s = STALL_BUB;
                        fl_s  = STALL_FL;
`ifdef CSR_SERIALIZE_EN
                    end else if (bus.csrD) begin
                        // CSR stays in ID until the drain reaches zero
                        bub_s           = STALL_BUB;
                        fl_s            = STALL_FL;
                        drain_cnt_nxt_s = 2'd3;
                        state_nxt_s     = DRAIN;
`endif
                    end else if (bus.jalD) begin
                        fl_s = JAL_FL;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MISS_WAIT: begin
                    miss_inc_s = 1'b1;
                    if (bus.mem_ack) begin
`ifdef CSR_SERIALIZE_EN
                        state_nxt_s = (drain_cnt_r != 2'd0) ? DRAIN : RUN;
`else
                        state_nxt_s = RUN;
`endif
                    end else begin
                        bub_s = ALL_5;
                    end
                end
`ifdef CSR_SERIALIZE_EN
                DRAIN: begin
                    if (bus.missM) begin
                        bub_s       = ALL_5;
                        state_nxt_s = MISS_WAIT;
                    end else if (redirect_s) begin
                        fl_s            = REDIR_FL;
                        drain_cnt_nxt_s = 2'd0;
                        state_nxt_s     = RUN;
                    end else if (drain_cnt_r != 2'd0) begin
                        bub_s           = STALL_BUB;
                        fl_s            = STALL_FL;
                        drain_cnt_nxt_s = drain_cnt_r - 2'd1;
                    end else begin
                        // count exhausted: the held CSR issues this cycle
                        state_nxt_s = RUN;
                        if (bus.jalD) begin
                            fl_s = JAL_FL;
                        end else begin
                            fl_s = NONE_5;
                        end
                    end
                end
`endif
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // State, drain counter and miss-cycle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RUN;
            miss_cycles_r <= 16'd0;
`ifdef CSR_SERIALIZE_EN
            drain_cnt_r   <= 2'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (miss_inc_s) begin
                miss_cycles_r <= sat_inc16(miss_cycles_r);
            end else begin
                miss_cycles_r <= miss_cycles_r;
            end
`ifdef CSR_SERIALIZE_EN
            drain_cnt_r <= drain_cnt_nxt_s;
`endif
        end
    end

    assign bus.bubbleF     = bub_s[4];
    assign bus.bubbleD     = bub_s[3];
    assign bus.bubbleE     = bub_s[2];
    assign bus.bubbleM     = bub_s[1];
    assign bus.bubbleW     = bub_s[0];
    assign bus.flushF      = fl_s[4];
    assign bus.flushD      = fl_s[3];
    assign bus.flushE      = fl_s[2];
    assign bus.flushM      = fl_s[1];
    assign bus.flushW      = fl_s[0];
    assign bus.miss_cycles = miss_cycles_r;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RUN-state vector table plus miss, reset-abort and CSR drain sequences.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // output word: {bubbleF,D,E,M,W, flushF,D,E,M,W}
    localparam logic [9:0] ZERO  = 10'b00000_00000;
    localparam logic [9:0] RSTO  = 10'b00000_11111;
    localparam logic [9:0] ALLB  = 10'b11111_00000;
    localparam logic [9:0] STALL = 10'b11000_00100;
    localparam logic [9:0] REDIR = 10'b00000_01100;
    localparam logic [9:0] JALF  = 10'b00000_01000;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       jr;
        logic       jd;
        logic       ack;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [9:0] outs();
        return {bus.bubbleF, bus.bubbleD, bus.bubbleE, bus.bubbleM, bus.bubbleW,
                bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.rs1D = 5'd0; bus.rs2D = 5'd0; bus.rs1_useD = 1'b0; bus.rs2_useD = 1'b0;
        bus.rdE = 5'd0; bus.mem_readE = 1'b0; bus.br_takenE = 1'b0; bus.jalrE = 1'b0;
        bus.jalD = 1'b0; bus.csrD = 1'b0; bus.missM = 1'b0; bus.mem_ack = 1'b0;
    endtask

    task automatic set_lu();
        bus.mem_readE = 1'b1; bus.rdE = 5'd5; bus.rs2D = 5'd5; bus.rs2_useD = 1'b1;
    endtask

    initial begin
        //          name          rs1    rs2    u1    u2    rd     mr    bt    jr    jd    ack   exp
        vecs[0]  = '{"idle",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ZERO};
        vecs[1]  = '{"lu_rs2",    5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STALL};
        vecs[2]  = '{"lu_rd0",    5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ZERO};
        vecs[3]  = '{"lu_nouse",  5'd7,  5'd3,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ZERO};
        vecs[4]  = '{"lu_rs1",    5'd7,  5'd3,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STALL};
        vecs[5]  = '{"no_load",   5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ZERO};
        vecs[6]  = '{"br_lu",     5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, REDIR};
        vecs[7]  = '{"jalr",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, REDIR};
        vecs[8]  = '{"jal",       5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, JALF};
        vecs[9]  = '{"jal_lu",    5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, STALL};
        vecs[10] = '{"jal_br",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, REDIR};
        vecs[11] = '{"ack_run",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ZERO};

        idle();
        bus.missM = 1'b1;
        #12;
        chk("reset_outs", outs(), RSTO);
        chk16("reset_misscyc", bus.miss_cycles, 16'd0);
        bus.missM = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post_reset", outs(), ZERO);
        chk16("post_reset_misscyc", bus.miss_cycles, 16'd0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle();
            bus.rs1D = vecs[i].rs1; bus.rs2D = vecs[i].rs2;
            bus.rs1_useD = vecs[i].u1; bus.rs2_useD = vecs[i].u2;
            bus.rdE = vecs[i].rd; bus.mem_readE = vecs[i].mr;
            bus.br_takenE = vecs[i].bt; bus.jalrE = vecs[i].jr;
            bus.jalD = vecs[i].jd; bus.mem_ack = vecs[i].ack;
            #2;
            chk(vecs[i].name, outs(), vecs[i].exp);
        end
        @(negedge clk);
        idle();
        #2;
        chk("after_ack_ignored", outs(), ZERO);

        // miss at cycle 10, ack at cycle 17
        @(negedge clk);
        bus.missM = 1'b1;
        #2;
        chk("miss_enter", outs(), ALLB);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #2;
            chk("miss_wait", outs(), ALLB);
        end
        @(negedge clk);
        bus.missM = 1'b0;
        bus.mem_ack = 1'b1;
        #2;
        chk("miss_ack", outs(), ZERO);
        chk16("misscyc_at_ack", bus.miss_cycles, 16'd6);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2;
        chk("post_miss", outs(), ZERO);
        chk16("misscyc_final", bus.miss_cycles, 16'd7);

        // miss beats a coincident load-use; the stall returns once RUN resumes
        @(negedge clk);
        set_lu();
        bus.missM = 1'b1;
        #2;
        chk("miss_over_lu", outs(), ALLB);
        @(negedge clk);
        bus.missM = 1'b0;
        #2;
        chk("lu_miss_wait", outs(), ALLB);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #2;
        chk("lu_miss_ack", outs(), ZERO);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2;
        chk("stall_reapplied", outs(), STALL);
        chk16("misscyc_9", bus.miss_cycles, 16'd9);

        // reset aborts MISS_WAIT asynchronously
        @(negedge clk);
        idle();
        bus.missM = 1'b1;
        @(negedge clk);
        bus.missM = 1'b0;
        #2;
        chk("abort_in_wait", outs(), ALLB);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_reset_outs", outs(), RSTO);
        chk16("abort_misscyc", bus.miss_cycles, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("abort_run", outs(), ZERO);
        @(negedge clk);
        #2;
        chk("abort_run2", outs(), ZERO);

`ifdef CSR_SERIALIZE_EN
        // CSR in RUN holds, then three DRAIN stalls, then issue
        @(negedge clk);
        bus.csrD = 1'b1;
        #2;
        chk("csr_detect", outs(), STALL);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            chk("csr_drain", outs(), STALL);
        end
        @(negedge clk);
        #2;
        chk("csr_issue", outs(), ZERO);
        @(negedge clk);
        bus.csrD = 1'b0;
        #2;
        chk("csr_after", outs(), ZERO);

        // miss at drain count 2 freezes the count
        @(negedge clk);
        bus.csrD = 1'b1;
        #2;
        chk("csr2_detect", outs(), STALL);
        @(negedge clk);
        #2;
        chk("csr2_drain3", outs(), STALL);
        @(negedge clk);
        bus.missM = 1'b1;
        #2;
        chk("csr2_miss", outs(), ALLB);
        @(negedge clk);
        bus.missM = 1'b0;
        #2;
        chk("csr2_wait", outs(), ALLB);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #2;
        chk("csr2_ack", outs(), ZERO);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2;
        chk("csr2_resume2", outs(), STALL);
        @(negedge clk);
        #2;
        chk("csr2_resume1", outs(), STALL);
        @(negedge clk);
        #2;
        chk("csr2_issue", outs(), ZERO);
        @(negedge clk);
        bus.csrD = 1'b0;
        #2;
        chk("csr2_after", outs(), ZERO);
`else
        // csrD has no effect without serialization
        @(negedge clk);
        bus.csrD = 1'b1;
        #2;
        chk("csr_ignored", outs(), ZERO);
        @(negedge clk);
        #2;
        chk("csr_ignored2", outs(), ZERO);
        @(negedge clk);
        bus.csrD = 1'b0;
        set_lu();
        #2;
        chk("csr_then_lu", outs(), STALL);
`endif

        @(negedge clk);
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: rs1D, rs2D  in  5 each  source register indices of the instruction in ID; rs1_useD, rs2_useD  in  1 each  source actually read.
REQ-004 SHALL have: rdE  in  5  destination register in EX; mem_readE  in  1  EX instruction is a load.
REQ-005 SHALL have: br_takenE, jalrE  in  1 each  redirect resolved in EX; jalD  in  1  JAL decoded in ID; csrD  in  1  CSR instruction in ID.
REQ-006 SHALL have: missM  in  1  data-cache miss for the MEM instruction; mem_ack  in  1  one-cycle refill-complete pulse.
REQ-007 SHALL have: bubbleF/D/E/M/W, flushF/D/E/M/W  out  1 each  hold and clear controls for the F, D, E, M, W segment registers; a segment register holds when its bubble is 1 and ignores its flush.
REQ-008 SHALL have: miss_cycles  out  16  count of cycles spent in MISS_WAIT, saturating.

Function
REQ-009 SHALL implement a state machine with states RUN, MISS_WAIT and DRAIN; all outputs except miss_cycles SHALL be combinational from the state, the counters and the inputs.
REQ-010 In RUN, missM=1 SHALL assert all five bubbles in that cycle, and the next state SHALL be MISS_WAIT.
REQ-011 In MISS_WAIT, all five bubbles SHALL be 1 while mem_ack=0; miss_cycles SHALL increment each cycle and saturate at 0xFFFF.
REQ-012 In MISS_WAIT, mem_ack=1 SHALL deassert all bubbles in that cycle, and the next state SHALL be RUN, or DRAIN if the drain count is nonzero.
REQ-013 A mem_ack pulse outside MISS_WAIT SHALL be ignored.
REQ-014 Load-use in RUN, when mem_readE=1, rdE!=0 and (rdE==rs1D with rs1_useD=1, or rdE==rs2D with rs2_useD=1): bubbleF=1, bubbleD=1, flushE=1 for exactly that cycle.
REQ-015 br_takenE=1 or jalrE=1 in RUN or DRAIN SHALL assert flushD=1 and flushE=1, SHALL suppress a load-use stall in that cycle, and SHALL clear the drain count.
REQ-016 jalD=1 with no EX redirect and no stall in that cycle SHALL assert flushD=1.
REQ-017 Priority, highest first: reset, miss (RUN/MISS_WAIT), EX redirect, DRAIN or load-use, jalD.
REQ-018 Outside reset, flushF, flushM and flushW SHALL be 0 and bubbleE, bubbleM and bubbleW SHALL be 0 unless a miss is active.
REQ-019 A missM that coincides with a redirect or load-use SHALL win; the redirect or stall SHALL be reapplied after return to RUN because its inputs persist.

Reset
REQ-020 When rst_n=0, the state SHALL be RUN, the drain count 0 and miss_cycles 0, all asynchronously.
REQ-021 While rst_n=0, all flush outputs SHALL be 1 and all bubble outputs SHALL be 0.
REQ-022 Reset SHALL abort MISS_WAIT or DRAIN immediately; the first cycle after release SHALL be RUN with no stall.

Configuration
REQ-023 Macro CSR_SERIALIZE_EN: when defined, csrD=1 in RUN with no miss and no redirect SHALL load a 2-bit drain count with 3 and enter DRAIN.
REQ-024 In DRAIN (CSR_SERIALIZE_EN only): bubbleF=1, bubbleD=1 and flushE=1, and the count SHALL decrement each cycle.
REQ-025 In DRAIN (CSR_SERIALIZE_EN only): a missM SHALL freeze the count and enter MISS_WAIT.
REQ-026 In DRAIN (CSR_SERIALIZE_EN only): at count 0 the state SHALL return to RUN and the CSR instruction SHALL issue in that cycle.
REQ-027 When CSR_SERIALIZE_EN is not defined, csrD SHALL be ignored, DRAIN SHALL be unreachable and the drain counter SHALL be absent.

Verification
REQ-028 Hold rst_n=0, then release → flushF..W=1 during reset; first cycle after release has all outputs 0 and miss_cycles=0.
REQ-029 mem_readE=1, rdE=5, rs2D=5, rs2_useD=1 for 1 cycle → bubbleF=bubbleD=flushE=1 in that cycle only; with rdE=0 → no stall.
REQ-030 missM=1 at cycle 10, mem_ack at cycle 17 → all bubbles=1 over cycles 10-16; cycle 17 all bubbles=0; miss_cycles=7.
REQ-031 br_takenE=1 together with a load-use match → flushD=flushE=1 and bubbleF=0.
REQ-032 CSR_SERIALIZE_EN defined, csrD=1 → 3 DRAIN cycles with bubbleF=bubbleD=flushE=1, then release.
REQ-033 CSR_SERIALIZE_EN defined, missM during drain count 2 → MISS_WAIT, then DRAIN resumes at count 2 after mem_ack.
